// File: rtl/toeplitz_pkg.sv
// Shared types and sizing helpers for the streaming Toeplitz extractor.
package toeplitz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Number of WIDTH-bit beats needed to carry the N+L-1 bit seed.
  function automatic int seed_beats(input int n, input int l, input int width);
    return (n + l - 1 + width - 1) / width;
  endfunction

  // Index width for a counter over 'count' positions, never narrower than 1.
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/toeplitz_seedreg.sv
// Seed storage for the Toeplitz extractor; presents the WIDTH matrix columns
// that multiply the raw bits at positions cnt .. cnt+WIDTH-1.
module toeplitz_seedreg
  import toeplitz_pkg::*;
#(
  parameter int N     = 256,
  parameter int L     = 128,
  parameter int WIDTH = 2,
  parameter int IDX_W = 1,
  parameter int CNT_W = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [CNT_W-1:0]            cnt,
  output logic [WIDTH-1:0][L-1:0]     cols
);

  localparam int SB = seed_beats(N, L, WIDTH);
  localparam int SW = SB * WIDTH;

  logic [SW-1:0] seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      seed <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < SB; b++) begin
        if (wr_idx == IDX_W'(b))
          seed[b*WIDTH +: WIDTH] <= wr_data;
      end
    end
  end

  // Raw bit j selects the seed window t[N-1-j +: L]; padding bits above S never reach it.
  always_comb begin
    cols = '0;
    for (int k = 0; k < WIDTH; k++)
      cols[k] = L'(seed >> (N - 1 - int'(cnt) - k));
  end

endmodule

// File: rtl/toeplitz_stream.sv
// Streaming Toeplitz-hash randomness extractor: N raw bits in, L bits out per
// block, seed loaded serially and reloadable at any time.
module toeplitz_stream
  import toeplitz_pkg::*;
#(
  parameter int N     = 256,
  parameter int L     = 128,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             seed_loaded,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [L-1:0]     out_data,
  input  logic             out_ready
);

  localparam int SB = seed_beats(N, L, WIDTH);
  localparam int BW = idx_width(SB);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(N - WIDTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(SB - 1);

  state_t               state, state_nxt;
  logic [BW-1:0]        beat_cnt;
  logic [CW-1:0]        cnt;
  logic [L-1:0]         y;
  logic [L-1:0]         y_nxt;
  logic [WIDTH-1:0][L-1:0] cols;
  logic [BW-1:0]        seed_idx;
  logic                 seed_start;
  logic                 accept;
  logic                 last_beat;

  assign seed_start = seed_valid && (state != ST_LOAD);
  assign seed_idx   = (state == ST_LOAD) ? beat_cnt : '0;

  toeplitz_seedreg #(
    .N     (N),
    .L     (L),
    .WIDTH (WIDTH),
    .IDX_W (BW),
    .CNT_W (CW)
  ) u_seedreg (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (seed_valid),
    .wr_idx  (seed_idx),
    .wr_data (seed_data),
    .cnt     (cnt),
    .cols    (cols)
  );

  assign seed_loaded = (state == ST_RUN);
  // Only the block-closing beat waits for the output register to drain.
  assign in_ready    = (state == ST_RUN) && !seed_valid &&
                       !((cnt == LAST_CNT) && out_valid && !out_ready);
  assign accept      = in_valid && in_ready;
  assign last_beat   = accept && (cnt == LAST_CNT);

  always_comb begin
    y_nxt = y;
    for (int k = 0; k < WIDTH; k++) begin
      if (in_data[k])
        y_nxt = y_nxt ^ cols[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (seed_valid)
          state_nxt = (SB == 1) ? ST_RUN : ST_LOAD;
      end
      ST_LOAD: begin
        if (seed_valid && (beat_cnt == LAST_BEAT))
          state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      cnt       <= '0;
      y         <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (seed_start)
        beat_cnt <= (SB > 1) ? BW'(1) : '0;
      else if ((state == ST_LOAD) && seed_valid)
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);

      // A seed restart abandons the partial block; a finished block is unaffected.
      if (seed_start) begin
        y   <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (last_beat) begin
          y   <= '0;
          cnt <= '0;
        end else begin
          y   <= y_nxt;
          cnt <= cnt + CW'(WIDTH);
        end
      end

      if (last_beat) begin
        out_data  <= y_nxt;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toeplitz_stream.sv
// Randomized bench for toeplitz_stream against a direct XOR-sum Toeplitz model.
module tb_toeplitz_stream;

  localparam int N     = 8;
  localparam int L     = 4;
  localparam int WIDTH = 2;
  localparam int S     = N + L - 1;
  localparam int SB    = (S + WIDTH - 1) / WIDTH;
  localparam int PW    = SB * WIDTH;

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  logic             seed_valid = 1'b0;
  logic [WIDTH-1:0] seed_data  = '0;
  logic             in_valid   = 1'b0;
  logic [WIDTH-1:0] in_data    = '0;
  logic             out_ready  = 1'b0;
  logic             seed_loaded;
  logic             in_ready;
  logic             out_valid;
  logic [L-1:0]     out_data;

  int checks = 0;
  int errors = 0;

  logic [S-1:0] ref_seed  = '0;
  logic [N-1:0] ref_blk   = '0;
  int           ref_nbits = 0;
  logic [L-1:0] exp_q[$];
  bit           rand_ready = 1'b0;
  bit           hold_prev  = 1'b0;
  logic [L-1:0] hold_data  = '0;

  always #5 clk = ~clk;

  toeplitz_stream #(.N(N), .L(L), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .seed_valid  (seed_valid),
    .seed_data   (seed_data),
    .seed_loaded (seed_loaded),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // out[i] = XOR_j d[j] & t[N-1-j+i]
  function automatic logic [L-1:0] ref_extract(input logic [S-1:0] t, input logic [N-1:0] d);
    logic [L-1:0] r;
    logic b;
    r = '0;
    for (int i = 0; i < L; i++) begin
      b = 1'b0;
      for (int j = 0; j < N; j++)
        b = b ^ (d[j] & t[N-1-j+i]);
      r[i] = b;
    end
    return r;
  endfunction

  // Observe accepted beats and output handshakes just before the edge that commits them.
  always @(negedge clk) begin
    if (!reset) begin
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < WIDTH; k++)
          ref_blk[ref_nbits + k] = in_data[k];
        ref_nbits += WIDTH;
        if (ref_nbits == N) begin
          exp_q.push_back(ref_extract(ref_seed, ref_blk));
          ref_nbits = 0;
        end
      end
      if (out_valid && out_ready) begin
        chk("out_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          chk("out_data", out_data, exp_q.pop_front());
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset      = 1'b1;
    seed_valid = 1'b0;
    ref_nbits  = 0;
    exp_q.delete();
    repeat (cycles) cyc();
    reset = 1'b0;
  endtask

  task automatic load_seed(input logic [S-1:0] t);
    logic [PW-1:0] padded;
    padded    = PW'({$urandom, t});
    ref_seed  = t;
    ref_nbits = 0;
    for (int b = 0; b < SB; b++) begin
      seed_valid = 1'b1;
      seed_data  = padded[b*WIDTH +: WIDTH];
      cyc();
      if (b == 0) chk("seed_loading", seed_loaded, 0);
    end
    seed_valid = 1'b0;
    chk("seed_loaded", seed_loaded, 1);
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int w = 0; w < 100 && !done; w++) begin
      @(negedge clk);
      done = in_ready;
      cyc();
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    if (!done) chk("beat_accept", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [N-1:0] d);
    for (int b = 0; b < N / WIDTH; b++)
      send_beat(d[b*WIDTH +: WIDTH]);
  endtask

  initial begin
    logic [N-1:0] d2;
    int nblk;

    do_reset(3);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    in_valid = 1'b1;
    in_data  = 2'b11;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_seed_loaded", seed_loaded, 0);
      chk("idle_out_valid", out_valid, 0);
      cyc();
    end
    in_valid = 1'b0;

    // Identity seed: out[i] = d[i]
    out_ready = 1'b1;
    load_seed(11'h080);
    send_beat(2'b11);
    send_beat(2'b00);
    send_beat(2'b00);
    chk("id_pre_valid", out_valid, 0);
    send_beat(2'b00);
    chk("id_valid", out_valid, 1);
    chk("id_data", out_data, 4'b0011);
    cyc();
    chk("id_clear", out_valid, 0);

    load_seed(11'h7FF);
    send_block(8'b00_00_00_01);
    chk("ones_single", out_data, 4'b1111);
    send_block(8'b01_01_01_01);
    chk("ones_even", out_data, 4'b0000);
    cyc();

    // Backpressure: second block's closing beat waits for the first to drain
    load_seed(S'($urandom));
    out_ready = 1'b0;
    send_block(N'($urandom));
    chk("bp_b1_valid", out_valid, 1);
    d2 = N'($urandom);
    for (int b = 0; b < N / WIDTH - 1; b++)
      send_beat(d2[b*WIDTH +: WIDTH]);
    in_valid = 1'b1;
    in_data  = d2[N-WIDTH +: WIDTH];
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", in_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    send_beat(d2[N-WIDTH +: WIDTH]);
    chk("bp_b2_valid", out_valid, 1);
    cyc();
    cyc();
    chk("bp_drained", out_valid, 0);

    // Reload mid-block with a pending output
    load_seed(S'($urandom));
    out_ready = 1'b0;
    send_block(N'($urandom));
    send_beat(WIDTH'($urandom));
    send_beat(WIDTH'($urandom));
    load_seed(S'($urandom));
    chk("reload_pending", out_valid, 1);
    out_ready = 1'b1;
    send_block(N'($urandom));
    cyc();
    cyc();

    // Reset in the middle of a seed load
    for (int b = 0; b < 3; b++) begin
      seed_valid = 1'b1;
      seed_data  = WIDTH'($urandom);
      cyc();
    end
    do_reset(1);
    chk("rl_seed_loaded", seed_loaded, 0);
    chk("rl_out_valid", out_valid, 0);
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rl_in_ready", in_ready, 0);
      cyc();
    end
    in_valid = 1'b0;

    // Reset in the middle of a block with an undelivered output
    load_seed(S'($urandom));
    out_ready = 1'b0;
    send_block(N'($urandom));
    send_beat(WIDTH'($urandom));
    do_reset(1);
    chk("rb_out_valid", out_valid, 0);
    chk("rb_out_data", out_data, 0);
    chk("rb_seed_loaded", seed_loaded, 0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("rb_in_ready", in_ready, 0);
    cyc();
    in_valid = 1'b0;

    // Random seeds, blocks, sink stalls and occasional mid-block reloads
    rand_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      load_seed(S'($urandom));
      nblk = $urandom_range(2, 4);
      for (int b = 0; b < nblk; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          for (int p = 0; p < $urandom_range(1, N / WIDTH - 1); p++)
            send_beat(WIDTH'($urandom));
          load_seed(S'($urandom));
        end
        send_block(N'($urandom));
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (5) cyc();
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
